// File: rtl/gps_ack_peak_pkg.sv
// Shared types and constants for the acquisition peak tracker.
package gps_ack_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned NUM_PHASES = 1024;
  localparam logic [11:0] MID        = 12'd2048;

  typedef struct packed {
    logic [4:0]  sat;
    logic [9:0]  phase;
    logic [11:0] peak;
    logic [11:0] second;
    logic        detect;
  } lane_result_t;

  typedef enum logic {RIDLE, RSEND} rpt_state_t;
  typedef enum logic {IDLE, TRACK}  trk_state_t;

  // Distance of an integrator value from the zero-correlation midpoint.
  function automatic logic [11:0] corr_mag(input logic [11:0] x, input logic [11:0] mid);
    return (x >= mid) ? (x - mid) : (mid - x);
  endfunction

endpackage

// File: rtl/gps_ack_peak_lane_tracker.sv
// Per-lane top-two magnitude tracker with peak phase.
// Optional GPS_ACK_PEAK_EXCL_ADJ_EN: samples within +/-1 phase of the
// current best never touch second (chip-neighbour leakage suppression).
module peak_lane_tracker #(
  parameter logic [11:0] MID = gps_ack_pkg::MID
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        upd,
  input  logic [11:0] x,
  input  logic [9:0]  p,
  output logic [11:0] nxt_best,
  output logic [11:0] nxt_second,
  output logic [9:0]  nxt_phase
);
  import gps_ack_pkg::*;

  logic [11:0] best;
  logic [11:0] second;
  logic [9:0]  best_phase;
  logic [11:0] mag;
  logic        adj;

  // Post-update values; exposed so a sweep-end sample lands in the snapshot.
  always_comb begin
    mag        = corr_mag(x, MID);
    nxt_best   = best;
    nxt_second = second;
    nxt_phase  = best_phase;
`ifdef GPS_ACK_PEAK_EXCL_ADJ_EN
    adj = (p == best_phase) | (p == best_phase + 10'd1) | (p == best_phase - 10'd1);
`else
    adj = 1'b0;
`endif
    if (mag > best) begin
      nxt_best  = mag;
      nxt_phase = p;
      if (!adj) nxt_second = best;
    end else if ((mag > second) && !adj) begin
      nxt_second = mag;
    end
  end

  // Tracker registers; clear has priority over an update.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      best       <= '0;
      second     <= '0;
      best_phase <= '0;
    end else if (upd) begin
      best       <= nxt_best;
      second     <= nxt_second;
      best_phase <= nxt_phase;
    end
  end

endmodule

// File: rtl/gps_ack_peak.sv
// Acquisition peak detector: four lane trackers, sweep-end snapshot and
// a valid/ready result stream. Optional feature macro:
// GPS_ACK_PEAK_EXCL_ADJ_EN (see peak_lane_tracker).
module gps_ack_peak #(
  parameter logic [11:0] PEAK_THRESH = 12'd300,
  parameter logic [11:0] PEAK_MARGIN = 12'd100,
  parameter logic [11:0] MID         = 12'd2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ack_start,
  input  logic        corr_complete,
  input  logic [9:0]  code_phase,
  input  logic [4:0]  sat0,
  input  logic [4:0]  sat1,
  input  logic [4:0]  sat2,
  input  logic [4:0]  sat3,
  input  logic [11:0] integrator_0,
  input  logic [11:0] integrator_1,
  input  logic [11:0] integrator_2,
  input  logic [11:0] integrator_3,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_sat,
  output logic [9:0]  res_phase,
  output logic [11:0] res_peak,
  output logic [11:0] res_second,
  output logic        res_detect,
  output logic        sweep_overflow,
  output logic        busy
);
  import gps_ack_pkg::*;

  trk_state_t   trk_state, trk_next;
  rpt_state_t   rpt_state, rpt_next;
  logic         tracking;
  logic         corr_d;
  logic         stb, sweep_end, last_accept, snap_load;
  logic [9:0]   p;
  logic [1:0]   lane;
  logic [11:0]  integ [NUM_LANES];
  logic [4:0]   sats  [NUM_LANES];
  logic [11:0]  nb    [NUM_LANES];
  logic [11:0]  ns    [NUM_LANES];
  logic [9:0]   np    [NUM_LANES];
  lane_result_t snap  [NUM_LANES];

  // Lane input fan-in and strobe qualification.
  always_comb begin
    integ[0] = integrator_0;
    integ[1] = integrator_1;
    integ[2] = integrator_2;
    integ[3] = integrator_3;
    sats[0]  = sat0;
    sats[1]  = sat1;
    sats[2]  = sat2;
    sats[3]  = sat3;
    p           = code_phase - 10'd1;
    stb         = corr_complete & ~corr_d & tracking & ~ack_start;
    sweep_end   = stb & (code_phase == '0);
    last_accept = (rpt_state == RSEND) & res_ready & (lane == 2'd3);
    snap_load   = sweep_end & ((rpt_state == RIDLE) | last_accept);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    peak_lane_tracker #(.MID(MID)) u_trk (
      .clk        (clk),
      .rst        (rst),
      .clr        (ack_start | sweep_end),
      .upd        (stb),
      .x          (integ[g]),
      .p          (p),
      .nxt_best   (nb[g]),
      .nxt_second (ns[g]),
      .nxt_phase  (np[g])
    );
  end

  // Edge detector for the correlator done level.
  always_ff @(posedge clk) begin
    if (rst) corr_d <= 1'b0;
    else     corr_d <= corr_complete;
  end

  // Tracking FSM state register.
  always_ff @(posedge clk) begin
    if (rst) trk_state <= IDLE;
    else     trk_state <= trk_next;
  end

  // Tracking FSM next state: once started it runs sweeps back-to-back.
  always_comb begin
    trk_next = trk_state;
    if (ack_start) trk_next = TRACK;
  end

  // Tracking FSM outputs.
  always_comb begin
    tracking = (trk_state == TRACK);
  end

  // Report FSM state register.
  always_ff @(posedge clk) begin
    if (rst) rpt_state <= RIDLE;
    else     rpt_state <= rpt_next;
  end

  // Report FSM next state; a snapshot on the final accepted beat chains on.
  always_comb begin
    rpt_next = rpt_state;
    case (rpt_state)
      RIDLE:   if (snap_load) rpt_next = RSEND;
      RSEND:   if (last_accept) rpt_next = snap_load ? RSEND : RIDLE;
      default: rpt_next = RIDLE;
    endcase
    if (ack_start) rpt_next = RIDLE;
  end

  // Report FSM outputs, taken from the held snapshot.
  always_comb begin
    res_valid  = (rpt_state == RSEND);
    res_sat    = res_valid ? snap[lane].sat    : '0;
    res_phase  = res_valid ? snap[lane].phase  : '0;
    res_peak   = res_valid ? snap[lane].peak   : '0;
    res_second = res_valid ? snap[lane].second : '0;
    res_detect = res_valid ? snap[lane].detect : 1'b0;
    busy       = tracking | (rpt_state != RIDLE);
  end

  // Beat index, snapshot capture and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane           <= '0;
      sweep_overflow <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) snap[i] <= '0;
    end else if (ack_start) begin
      lane           <= '0;
      sweep_overflow <= 1'b0;
    end else begin
      if (snap_load) begin
        lane <= '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          snap[i].sat    <= sats[i];
          snap[i].phase  <= np[i];
          snap[i].peak   <= nb[i];
          snap[i].second <= ns[i];
          snap[i].detect <= (nb[i] >= PEAK_THRESH) && ((nb[i] - ns[i]) >= PEAK_MARGIN);
        end
      end else if (res_valid && res_ready) begin
        lane <= lane + 2'd1;
      end
      if (sweep_end && !snap_load) sweep_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gps_ack_peak.sv
// Scoreboard bench for gps_ack_peak: directed sweeps push expected beats,
// a negedge monitor pops and compares each accepted beat.
module tb_gps_ack_peak;
  import gps_ack_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ack_start = 1'b0;
  logic        corr_complete = 1'b0;
  logic [9:0]  code_phase = '0;
  logic [4:0]  sat0 = 5'd1, sat1 = 5'd7, sat2 = 5'd12, sat3 = 5'd31;
  logic [11:0] integrator_0 = 12'd2048, integrator_1 = 12'd2048;
  logic [11:0] integrator_2 = 12'd2048, integrator_3 = 12'd2048;
  logic        res_valid, res_ready = 1'b0;
  logic [4:0]  res_sat;
  logic [9:0]  res_phase;
  logic [11:0] res_peak, res_second;
  logic        res_detect, sweep_overflow, busy;

  gps_ack_peak #(.PEAK_THRESH(12'd300), .PEAK_MARGIN(12'd100), .MID(12'd2048)) dut (
    .clk(clk), .rst(rst), .ack_start(ack_start), .corr_complete(corr_complete),
    .code_phase(code_phase), .sat0(sat0), .sat1(sat1), .sat2(sat2), .sat3(sat3),
    .integrator_0(integrator_0), .integrator_1(integrator_1),
    .integrator_2(integrator_2), .integrator_3(integrator_3),
    .res_valid(res_valid), .res_ready(res_ready), .res_sat(res_sat),
    .res_phase(res_phase), .res_peak(res_peak), .res_second(res_second),
    .res_detect(res_detect), .sweep_overflow(sweep_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  lane_result_t exp_q[$];
  logic [11:0] vals [4][1024];
  int          dbl_phase = -1;
  logic [11:0] dbl_val = '0;
  logic [4:0]  sats [4] = '{5'd1, 5'd7, 5'd12, 5'd31};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  task automatic push(input int ln, input int ph, input int pk, input int sec, input bit det);
    lane_result_t r;
    r.sat = sats[ln]; r.phase = 10'(ph); r.peak = 12'(pk); r.second = 12'(sec); r.detect = det;
    exp_q.push_back(r);
  endtask

  task automatic push_empty(input int ln);
    push(ln, 0, 0, 0, 1'b0);
  endtask

  task automatic clear_vals();
    for (int l = 0; l < 4; l++)
      for (int ph = 0; ph < 1024; ph++) vals[l][ph] = 12'd2048;
    dbl_phase = -1;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One full sweep; each phase is a one-cycle strobe followed by a low cycle.
  task automatic do_sweep(input bit sync_last, input bit chk_lat);
    for (int ph = 0; ph < 1024; ph++) begin
      if (ph == 1023 && sync_last) begin
        res_ready = 1'b1;
        cyc(3);
      end
      code_phase    = 10'((ph + 1) % 1024);
      integrator_0  = vals[0][ph];
      integrator_1  = vals[1][ph];
      integrator_2  = vals[2][ph];
      integrator_3  = vals[3][ph];
      corr_complete = 1'b1;
      if (ph == 1023 && chk_lat) chk("valid_before_end", res_valid, 0);
      cyc(1);
      if (ph == 1023 && chk_lat) chk("valid_latency", res_valid, 1);
      if (ph == 1023 && sync_last) res_ready = 1'b0;
      if (ph == dbl_phase) begin
        integrator_3 = dbl_val;
        cyc(1);
      end
      corr_complete = 1'b0;
      cyc(1);
    end
  endtask

  // Monitor: every accepted beat is compared with the head of the queue.
  always @(negedge clk) begin
    lane_result_t got, e;
    if (!rst && res_valid && res_ready) begin
      got.sat = res_sat; got.phase = res_phase; got.peak = res_peak;
      got.second = res_second; got.detect = res_detect;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got sat=%0d phase=%0d peak=%0d second=%0d det=%0d, want none",
                 got.sat, got.phase, got.peak, got.second, got.detect);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat: got sat=%0d phase=%0d peak=%0d second=%0d det=%0d, want sat=%0d phase=%0d peak=%0d second=%0d det=%0d",
                   got.sat, got.phase, got.peak, got.second, got.detect,
                   e.sat, e.phase, e.peak, e.second, e.detect);
        end
      end
    end
  end

  initial begin
    cyc(3);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", sweep_overflow, 0);
    chk("rst_peak", res_peak, 0);
    rst = 1'b0;
    cyc(1);
    chk("idle_busy", busy, 0);
    ack_start = 1'b1; cyc(1); ack_start = 1'b0;
    chk("track_busy", busy, 1);

    // Sweep A: basic peak, second, tie, double-cycle strobe on lane3.
    clear_vals();
    vals[0][517] = 12'd200;
    vals[1][10]  = 12'd2448; vals[1][600] = 12'd1698;
    vals[2][3]   = 12'd2748; vals[2][900] = 12'd1348;
    vals[3][50]  = 12'd2368; dbl_phase = 50; dbl_val = 12'd3048;
    push(0, 517, 1848, 0, 1'b1);
    push(1, 10, 400, 350, 1'b0);
    push(2, 3, 700, 700, 1'b0);
    push(3, 50, 320, 0, 1'b1);
    res_ready = 1'b0;
    do_sweep(1'b0, 1'b1);
    chk("a_held_peak", res_peak, 1848);
    chk("a_overflow", sweep_overflow, 0);
    res_ready = 1'b1;
    cyc(6);
    chk("a_drained", res_valid, 0);

    // Sweep B: trackers cleared by previous sweep end; lane1 margin now met.
    clear_vals();
    vals[1][10] = 12'd2548; vals[1][600] = 12'd1698;
    push_empty(0); push(1, 10, 500, 350, 1'b1); push_empty(2); push_empty(3);
    do_sweep(1'b0, 1'b0);
    cyc(6);

    // Sweeps C/D: D ends while C is still unacknowledged.
    clear_vals();
    vals[0][5] = 12'd2648;
    push(0, 5, 600, 0, 1'b1); push_empty(1); push_empty(2); push_empty(3);
    res_ready = 1'b0;
    do_sweep(1'b0, 1'b0);
    clear_vals();
    do_sweep(1'b0, 1'b0);
    chk("d_overflow", sweep_overflow, 1);
    chk("d_still_c_peak", res_peak, 600);
    res_ready = 1'b1;
    cyc(6);
    chk("d_dropped", res_valid, 0);
    res_ready = 1'b0;

    // Sweep E: report pending, then ack_start discards it.
    do_sweep(1'b0, 1'b0);
    chk("e_valid", res_valid, 1);
    chk("e_overflow_sticky", sweep_overflow, 1);
    ack_start = 1'b1; cyc(1); ack_start = 1'b0;
    chk("ack_valid", res_valid, 0);
    chk("ack_overflow", sweep_overflow, 0);
    chk("ack_busy", busy, 1);

    // Sweep F: threshold/margin boundaries and a peak at phase 1023.
    clear_vals();
    vals[0][0]    = 12'd1748;
    vals[1][200]  = 12'd2448; vals[1][300] = 12'd2348;
    vals[2][1023] = 12'd2448;
    push(0, 0, 300, 0, 1'b1); push(1, 200, 400, 300, 1'b1);
    push(2, 1023, 400, 0, 1'b1); push_empty(3);
    do_sweep(1'b0, 1'b0);

    // Sweep G: its end coincides with acceptance of F's last beat.
    clear_vals();
    vals[0][1]   = 12'd0;
    vals[3][700] = 12'd4095;
    push(0, 1, 2048, 0, 1'b1); push_empty(1); push_empty(2); push(3, 700, 2047, 0, 1'b1);
    do_sweep(1'b1, 1'b0);
    chk("g_overflow", sweep_overflow, 0);
    chk("g_valid", res_valid, 1);
    res_ready = 1'b1;
    cyc(6);

    // Sweep H: adjacent-phase leakage.
    clear_vals();
    vals[0][100] = 12'd2948; vals[0][101] = 12'd2898; vals[0][700] = 12'd2348;
`ifdef GPS_ACK_PEAK_EXCL_ADJ_EN
    push(0, 100, 900, 300, 1'b1);
`else
    push(0, 100, 900, 850, 1'b0);
`endif
    push_empty(1); push_empty(2); push_empty(3);
    do_sweep(1'b0, 1'b0);
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) cyc(1);
    chk("queue_empty", exp_q.size(), 0);
    chk("end_valid", res_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
